sram_burst_reader: RTL and testbench
====================================

SRAM_BURST_READER -- requirements
Module: sram_burst_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, the number of words in the attached sram_sp.
REQ-002 SHALL have parameter WIDTH, default 512, the data word width.
REQ-003 SHALL have parameter ADDR_BITS, default $clog2(DEPTH), the address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, a burst request, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_BITS, the first word address, sampled with start.
REQ-008 SHALL have port len, input, ADDR_BITS+1, the word count, sampled with start; legal range 0..DEPTH.
REQ-009 SHALL have port sram_ce, output, 1, the SRAM chip enable.
REQ-010 SHALL have port sram_we, output, 1, tied to 0.
REQ-011 SHALL have port sram_addr, output, ADDR_BITS, the SRAM address.
REQ-012 SHALL have port sram_din, output, WIDTH, tied to 0.
REQ-013 SHALL have port sram_dout, input, WIDTH; read data is valid one cycle after an sram_ce=1 cycle and holds while sram_ce=0.
REQ-014 SHALL have port m_valid, output, 1, the output stream valid.
REQ-015 SHALL have port m_ready, input, 1, the output stream ready.
REQ-016 SHALL have port m_data, output, WIDTH, the output stream data.
REQ-017 SHALL have port m_last, output, 1, asserted with the final beat of the burst.
REQ-018 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-019 SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, RUN and DRAIN.
REQ-021 IDLE SHALL go to RUN on start with len>0, latching base_addr into an address register and len into both an issue counter and a beat counter.
REQ-022 IDLE with start and len=0 SHALL stay in IDLE, issue no read, emit no beat, and pulse done in the next cycle.
REQ-023 start SHALL be ignored in RUN and DRAIN.
REQ-024 A read SHALL be issued in a cycle (sram_ce=1, sram_addr=address register) only in RUN, with the issue counter >0 and (buffered beats + in-flight reads − beats popped this cycle) < 2.
REQ-025 On each issue, the address register SHALL increment modulo DEPTH (DEPTH−1 wraps to 0) and the issue counter SHALL decrement.
REQ-026 Read data SHALL be captured from sram_dout, exactly one cycle after its issue, into a 2-entry FIFO output buffer; the buffer SHALL never overflow and SHALL never capture stale dout.
REQ-027 m_valid SHALL be high whenever the buffer is non-empty; m_data SHALL be the head entry; a beat SHALL be accepted when m_valid and m_ready are both high.
REQ-028 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-029 Beats SHALL be delivered in address order, with exactly len beats per burst.
REQ-030 m_last SHALL be high only on the head beat when the beat counter equals 1; the beat counter SHALL decrement on each acceptance.
REQ-031 RUN SHALL go to DRAIN when the issue counter reaches 0.
REQ-032 DRAIN SHALL go to IDLE on acceptance of the last beat, and done SHALL be high for exactly the following cycle.
REQ-033 With m_ready held high, the block SHALL sustain 1 beat per cycle; the first m_valid SHALL occur 2 cycles after the start sample edge.
REQ-034 With len=DEPTH, every address SHALL be read exactly once, wrapping from base_addr.
REQ-035 Outside an issue cycle, sram_ce SHALL be 0 and sram_addr SHALL hold its last value.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, clear the counters, the address register and the buffer, and drive sram_ce=0, sram_addr=0, m_valid=0, m_last=0, m_data=0, busy=0 and done=0.
REQ-037 rst mid-burst SHALL discard all in-flight and buffered data; no beat and no done SHALL follow the release of reset until a new start.

Verification
REQ-038 SRAM preloaded with mem[i]=i; base=3, len=4, m_ready=1 -> beats 3,4,5,6 on consecutive cycles, m_last on 6, done pulse the next cycle.
REQ-039 base=30, len=4, DEPTH=32 -> sram_addr sequence 30,31,0,1; beats in that order.
REQ-040 base=0, len=5, m_ready toggling 1,0,0,1,... -> no beat lost or duplicated, m_data stable while stalled, at most 2 reads outstanding plus buffered.
REQ-041 start with len=0 -> no sram_ce, no m_valid, done pulse 1 cycle later; start asserted during RUN -> ignored.
REQ-042 rst asserted after 2 beats of a len=8 burst -> all outputs 0 immediately; after release, no activity until start; a new base=0, len=2 burst returns 0,1.

Source files
------------

// File: rtl/sram_burst_reader.sv
// sram_burst_reader
//   Reads a burst of consecutive words from a single-port SRAM with one-cycle
//   read latency and presents them as a valid/ready stream.
//   A burst starts at base_addr and covers len words. Addresses wrap modulo DEPTH.
//   Reads are throttled so that buffered plus in-flight words never exceed the
//   2-entry output buffer. With m_ready held high, one beat is delivered per cycle.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start/base_addr/len   burst request, sampled only while idle
//   sram_ce/we/addr/din   SRAM command (we and din are tied to 0)
//   sram_dout             SRAM read data, valid one cycle after sram_ce
//   m_valid/ready/data    output stream
//   m_last                marks the final beat of the burst
//   busy                  high while a burst is in progress
//   done                  one-cycle pulse after the burst completes
module sram_burst_reader #(
   parameter int DEPTH     = 32,
   parameter int WIDTH     = 512,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [ADDR_BITS:0]   len,
   output logic                 sram_ce,
   output logic                 sram_we,
   output logic [ADDR_BITS-1:0] sram_addr,
   output logic [WIDTH-1:0]     sram_din,
   input  logic [WIDTH-1:0]     sram_dout,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [WIDTH-1:0]     m_data,
   output logic                 m_last,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [ADDR_BITS:0]   CNT_ZERO  = '0;
   localparam logic [ADDR_BITS:0]   CNT_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
   localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(DEPTH - 1);

   state_t                 state_reg, state_next;
   logic [ADDR_BITS-1:0]   addr_reg;
   logic [ADDR_BITS-1:0]   addr_hold_reg;
   logic [ADDR_BITS:0]     issue_cnt_reg;
   logic [ADDR_BITS:0]     beat_cnt_reg;
   logic                   inflight_reg;
   logic [1:0]             count_reg;
   logic                   wr_ptr_reg;
   logic                   rd_ptr_reg;
   logic [WIDTH-1:0]       buf_mem [0:1];
   logic                   done_reg;

   logic                   accept_start;
   logic                   issue;
   logic                   pop;
   logic                   push;
   logic [2:0]             occupancy;

   assign accept_start = (state_reg == IDLE) && start && (len != CNT_ZERO);
   assign pop          = (count_reg != 2'd0) && m_ready;
   // The word issued last cycle is on sram_dout now; capture it exactly once.
   assign push         = inflight_reg;
   assign occupancy    = {1'b0, count_reg} + {2'b00, inflight_reg};
   // A beat leaving this cycle frees a slot, so it may be reused immediately.
   assign issue        = (state_reg == RUN) && (issue_cnt_reg != CNT_ZERO) &&
                         (occupancy < (3'd2 + {2'b00, pop}));

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept_start) state_next = RUN;
         RUN:     if (issue && issue_cnt_reg == CNT_ONE) state_next = DRAIN;
         DRAIN:   if (pop && beat_cnt_reg == CNT_ONE) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Address and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg      <= '0;
         addr_hold_reg <= '0;
         issue_cnt_reg <= '0;
         beat_cnt_reg  <= '0;
         inflight_reg  <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (accept_start) begin
            addr_reg      <= base_addr;
            issue_cnt_reg <= len;
            beat_cnt_reg  <= len;
         end else begin
            if (issue) begin
               addr_reg      <= (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
               addr_hold_reg <= addr_reg;
               issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
            end
            if (pop) beat_cnt_reg <= beat_cnt_reg - CNT_ONE;
         end
      end
   end

   // Two-entry output FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_buf
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                                   buf_mem[gi] <= '0;
            else if (push && (wr_ptr_reg == 1'(gi)))   buf_mem[gi] <= sram_dout;
         end
      end
   endgenerate

   // Completion pulse: zero-length request, or acceptance of the final beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) done_reg <= 1'b0;
      else     done_reg <= ((state_reg == IDLE) && start && (len == CNT_ZERO)) ||
                           ((state_reg == DRAIN) && pop && (beat_cnt_reg == CNT_ONE));
   end

   assign sram_ce   = issue;
   assign sram_we   = 1'b0;
   assign sram_din  = '0;
   // Address holds its last issued value between reads.
   assign sram_addr = issue ? addr_reg : addr_hold_reg;
   assign m_valid   = (count_reg != 2'd0);
   assign m_data    = buf_mem[rd_ptr_reg];
   assign m_last    = m_valid && (beat_cnt_reg == CNT_ONE);
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;
   localparam int DEPTH = 32;
   localparam int WIDTH = 512;
   localparam int AB    = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [AB-1:0]     base_addr;
   logic [AB:0]       len;
   logic              sram_ce, sram_we;
   logic [AB-1:0]     sram_addr;
   logic [WIDTH-1:0]  sram_din;
   logic [WIDTH-1:0]  sram_dout;
   logic              m_valid, m_ready, m_last, busy, done;
   logic [WIDTH-1:0]  m_data;

   sram_burst_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_BITS(AB)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // SRAM model: mem[i] = i, one-cycle read latency, dout holds otherwise
   logic [WIDTH-1:0] mem [0:DEPTH-1];
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
      sram_dout = '0;
   end
   always @(posedge clk) if (sram_ce && !sram_we) sram_dout <= mem[sram_addr];

   // Scoreboard state
   int               tests = 0, fails = 0;
   int               exp_addr[$];
   logic [WIDTH-1:0] exp_data[$];
   logic             exp_last[$];
   logic             done_exp = 1'b0, done_next_req = 1'b0;
   int               outstanding = 0, beats_accepted = 0;
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   int               ready_mode = 0, tog_idx = 0;

   task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(string name);
      tests++;
      fails++;
      $display("FAIL %s: got event expected none at %0t", name, $time);
   endtask

   // Ready driver
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         2:       begin m_ready = (tog_idx % 3 == 0); tog_idx++; end
         3:       m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b1;
      endcase
   end

   // Monitor: compares DUT outputs against the queues on every falling edge
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         done_exp   = 1'b0;
      end else begin
         chk("done", WIDTH'(done), WIDTH'(done_exp));
         done_exp      = done_next_req;
         done_next_req = 1'b0;
         if (sram_we !== 1'b0 || sram_din !== '0) fail_evt("sram_we_din");
         if (sram_ce) begin
            if (exp_addr.size() == 0) fail_evt("unexpected_read");
            else chk("sram_addr", WIDTH'(sram_addr), WIDTH'(exp_addr.pop_front()));
            outstanding++;
         end
         if (stall_prev) begin
            chk("stall_valid", WIDTH'(m_valid), WIDTH'(1));
            chk("stall_data", m_data, prev_data);
         end
         if (m_valid && m_ready) begin
            if (exp_data.size() == 0) fail_evt("unexpected_beat");
            else begin
               logic l;
               chk("m_data", m_data, exp_data.pop_front());
               l = exp_last.pop_front();
               chk("m_last", WIDTH'(m_last), WIDTH'(l));
               if (l) done_exp = 1'b1;
            end
            outstanding--;
            beats_accepted++;
            $display("[TB] beat %0h last=%0b", m_data[31:0], m_last);
         end else if (m_valid && exp_data.size() == 0) begin
            fail_evt("spurious_valid");
         end
         if (outstanding > 2) fail_evt("outstanding_over_2");
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   task automatic start_burst(int b, int l);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = AB'(b);
      len = (AB + 1)'(l);
      for (int k = 0; k < l; k++) begin
         exp_addr.push_back((b + k) % DEPTH);
         exp_data.push_back(mem[(b + k) % DEPTH]);
         exp_last.push_back(k == l - 1);
      end
      if (l == 0) done_next_req = 1'b1;
      $display("[TB] start base=%0d len=%0d ready_mode=%0d", b, l, ready_mode);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = (exp_data.size() == 0) && (exp_addr.size() == 0) && !busy && !done &&
              !done_exp && !done_next_req;
      end
      if (!ok) fail_evt("burst_timeout");
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_sram_ce"}, WIDTH'(sram_ce), '0);
      chk({tag, "_sram_addr"}, WIDTH'(sram_addr), '0);
      chk({tag, "_m_valid"}, WIDTH'(m_valid), '0);
      chk({tag, "_m_last"}, WIDTH'(m_last), '0);
      chk({tag, "_m_data"}, m_data, '0);
      chk({tag, "_busy"}, WIDTH'(busy), '0);
      chk({tag, "_done"}, WIDTH'(done), '0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
      #3;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Directed: base 3, len 4, ready high -- latency and back-to-back beats
      ready_mode = 0;
      start_burst(3, 4);
      @(negedge clk);
      chk("lat_valid_c1", WIDTH'(m_valid), '0);
      chk("busy_run", WIDTH'(busy), WIDTH'(1));
      @(negedge clk);
      chk("lat_valid_c2", WIDTH'(m_valid), '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("consec_valid", WIDTH'(m_valid), WIDTH'(1));
         chk("consec_data", m_data, WIDTH'(3 + k));
      end
      @(negedge clk);
      chk("done_after_last", WIDTH'(done), WIDTH'(1));
      wait_idle();

      // Wrap-around
      start_burst(30, 4);
      wait_idle();

      // Stalling ready 1,0,0,1,...
      ready_mode = 2; tog_idx = 0;
      start_burst(0, 5);
      wait_idle();

      // Zero-length request
      ready_mode = 0;
      start_burst(7, 0);
      wait_idle();

      // start during a burst is ignored
      ready_mode = 2;
      start_burst(10, 6);
      repeat (3) @(posedge clk);
      #1 start = 1'b1; base_addr = AB'(20); len = (AB + 1)'(3);
      @(posedge clk); #1 start = 1'b0;
      wait_idle();

      // Reset mid-burst
      ready_mode = 0;
      begin
         int b0 = beats_accepted;
         start_burst(0, 8);
         for (int i = 0; i < 100 && beats_accepted < b0 + 2; i++) @(negedge clk);
         if (beats_accepted < b0 + 2) fail_evt("reset_wait_timeout");
      end
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_addr.delete(); exp_data.delete(); exp_last.delete();
      outstanding = 0; done_next_req = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_rst_busy", WIDTH'(busy), '0);
      start_burst(0, 2);
      wait_idle();

      // Randomized bursts
      for (int n = 0; n < 25; n++) begin
         ready_mode = (n % 2 == 0) ? 3 : int'($urandom_range(0, 3));
         start_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)));
         wait_idle();
      end
      // Full-depth burst
      ready_mode = 3;
      start_burst(17, DEPTH);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
